// File: rtl/lcs_pkg.sv
// Shared types and constants for the lcs_pipe lookahead subtractor.
package lcs_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int GRP       = 4;

    typedef logic [WIDTH_DEF-1:0]   word_t;
    typedef logic [WIDTH_DEF/2-1:0] half_t;

endpackage : lcs_pkg

// File: rtl/lcs_half.sv
// Combinational W-bit borrow-lookahead subtractor slice: d = x - y - bi, bo = borrow out.
// Bits are grouped GRP at a time; each group forms a group generate/propagate to skip the borrow.
module lcs_half
    import lcs_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    localparam int NGRP = (W + GRP - 1) / GRP;

    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         bc;
    logic         bb;
    logic         gg;
    logic         gp;

    // Borrow generate where x=0,y=1; borrow propagates through equal bits.
    assign g = ~x & y;
    assign p = ~(x ^ y);

    always_comb begin
        // NOTE: every variable gets a default before any conditional code so no latch is inferred;
        // blocking assignments are used here because the loop chains each value into the next.
        d  = '0;
        bc = bi;
        bb = 1'b0;
        gg = 1'b0;
        gp = 1'b1;
        for (int k = 0; k < NGRP; k++) begin
            bb = bc;
            gg = 1'b0;
            gp = 1'b1;
            for (int j = 0; j < GRP; j++) begin
                if (k * GRP + j < W) begin
                    d[k*GRP+j] = x[k*GRP+j] ^ y[k*GRP+j] ^ bb;
                    bb = g[k*GRP+j] | (p[k*GRP+j] & bb);
                    gg = g[k*GRP+j] | (p[k*GRP+j] & gg);
                    gp = gp & p[k*GRP+j];
                end
            end
            // Group-level lookahead: the next group's borrow-in skips the in-group chain.
            bc = gg | (gp & bc);
        end
    end

    assign bo = bc;

endmodule : lcs_half

// File: rtl/lcs_pipe.sv
// Two-stage pipelined lookahead subtractor (diff = a - b - bin) with valid/ready on both sides.
// Optional macro LCS_OVF_EN adds a registered signed-overflow output 'ovf'.
module lcs_pipe
    import lcs_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef LCS_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int HALF = WIDTH / 2;

    logic            s1_valid_q, s1_valid_d;
    logic [HALF-1:0] s1_lo_q,    s1_lo_d;
    logic            s1_bmid_q,  s1_bmid_d;
    logic [HALF-1:0] s1_ahi_q,   s1_ahi_d;
    logic [HALF-1:0] s1_bhi_q,   s1_bhi_d;
    logic            s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] diff_q,    diff_d;
    logic            bout_q,     bout_d;
    logic            ovf_q,      ovf_d;

    logic [HALF-1:0] lo_diff;
    logic            lo_bout;
    logic [HALF-1:0] hi_diff;
    logic            hi_bout;
    logic            s1_adv;
    logic            s2_adv;

    lcs_half #(.W(HALF)) u_lo (
        .x  (a[HALF-1:0]),
        .y  (b[HALF-1:0]),
        .bi (bin),
        .d  (lo_diff),
        .bo (lo_bout)
    );

    lcs_half #(.W(HALF)) u_hi (
        .x  (s1_ahi_q),
        .y  (s1_bhi_q),
        .bi (s1_bmid_q),
        .d  (hi_diff),
        .bo (hi_bout)
    );

    // Stage 2 drains when empty or when downstream takes its result; stage 1 follows.
    assign s2_adv   = s1_valid_q & (~s2_valid_q | out_ready);
    assign in_ready = ~s1_valid_q | s2_adv;
    assign s1_adv   = in_valid & in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_lo_d    = s1_lo_q;
        s1_bmid_d  = s1_bmid_q;
        s1_ahi_d   = s1_ahi_q;
        s1_bhi_d   = s1_bhi_q;
        s2_valid_d = s2_valid_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        ovf_d      = ovf_q;

        if (s1_adv) begin
            s1_valid_d = 1'b1;
            s1_lo_d    = lo_diff;
            s1_bmid_d  = lo_bout;
            s1_ahi_d   = a[WIDTH-1:HALF];
            s1_bhi_d   = b[WIDTH-1:HALF];
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = 1'b1;
            diff_d     = {hi_diff, s1_lo_q};
            bout_d     = hi_bout;
            ovf_d      = (s1_ahi_q[HALF-1] ^ s1_bhi_q[HALF-1]) & (hi_diff[HALF-1] ^ s1_ahi_q[HALF-1]);
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            // NOTE: datapath registers are cleared as well as the valids so diff/bout read 0 after reset.
            s1_valid_q <= 1'b0;
            s1_lo_q    <= '0;
            s1_bmid_q  <= 1'b0;
            s1_ahi_q   <= '0;
            s1_bhi_q   <= '0;
            s2_valid_q <= 1'b0;
            diff_q     <= '0;
            bout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lo_q    <= s1_lo_d;
            s1_bmid_q  <= s1_bmid_d;
            s1_ahi_q   <= s1_ahi_d;
            s1_bhi_q   <= s1_bhi_d;
            s2_valid_q <= s2_valid_d;
            diff_q     <= diff_d;
            bout_q     <= bout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

`ifdef LCS_OVF_EN
    assign ovf = ovf_q;
`else
    // Overflow is only exported when the feature is enabled.
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule : lcs_pipe

// File: tb/tb_lcs_pipe.sv
// Directed self-checking bench for lcs_pipe; expected values are hand-computed constants.
// Build with LCS_OVF_EN defined to also check the overflow output.
module tb_lcs_pipe;

    import lcs_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    logic  in_ready;
    word_t a;
    word_t b;
    logic  bin;
    logic  out_valid;
    logic  out_ready;
    word_t diff;
    logic  bout;
`ifdef LCS_OVF_EN
    logic  ovf;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    lcs_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef LCS_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with out_ready high; checks the two-register latency.
    task automatic run_vec(input string tag, input word_t va, input word_t vb, input logic vbin,
                           input word_t exp_d, input logic exp_bo, input logic exp_ovf);
        a = va; b = vb; bin = vbin; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 32'(out_valid), 32'h0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'h1);
        check({tag, "_diff"},  32'(diff),      32'(exp_d));
        check({tag, "_bout"},  32'(bout),      32'(exp_bo));
`ifdef LCS_OVF_EN
        check({tag, "_ovf"},   32'(ovf),       32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: unknown ovf expectation for %s", tag);
`endif
        tick();
    endtask

    word_t bp_a   [4] = '{16'h1234, 16'h0010, 16'hFFFF, 16'h8000};
    word_t bp_b   [4] = '{16'h0234, 16'h0020, 16'h0001, 16'h8000};
    logic  bp_bin [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [16:0] bp_exp [4] = '{{1'b0, 16'h1000}, {1'b1, 16'hFFEF}, {1'b0, 16'hFFFE}, {1'b1, 16'hFFFF}};

    initial begin
        int sent;
        int got;
        int stale;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_diff",      32'(diff),      32'h0);
        check("rst_bout",      32'(bout),      32'h0);
        check("rst_in_ready",  32'(in_ready),  32'h1);
        tick();

        run_vec("v0",  16'h90AF, 16'h6FAF, 1'b0, 16'h2100, 1'b0, 1'b1);
        run_vec("v1",  16'h90AF, 16'h6FAF, 1'b1, 16'h20FF, 1'b0, 1'b1);
        run_vec("v2",  16'hAF90, 16'hAF6F, 1'b0, 16'h0021, 1'b0, 1'b0);
        run_vec("v3",  16'hAF90, 16'hAF6F, 1'b1, 16'h0020, 1'b0, 1'b0);
        run_vec("v4",  16'h0002, 16'h0006, 1'b0, 16'hFFFC, 1'b1, 1'b0);
        run_vec("v5",  16'h5555, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1, 1'b1);
        run_vec("v6",  16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_vec("ov0", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        run_vec("ov1", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);

        // Backpressure: out_ready low for the first 3 cycles of a 4-vector stream.
        sent = 0;
        got  = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = (c >= 3);
            if (sent < 4) begin
                a = bp_a[sent]; b = bp_b[sent]; bin = bp_bin[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 2) begin
                check("bp_accepts", 32'(sent), 32'h2);
                check("bp_in_ready_low", 32'(in_ready), 32'h0);
            end
            if (c == 2 || c == 3) begin
                check("bp_hold_valid", 32'(out_valid), 32'h1);
                check("bp_hold_diff",  32'(diff),      32'(bp_exp[0][15:0]));
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 4) check($sformatf("bp_order%0d", got), 32'({bout, diff}), 32'(bp_exp[got]));
                else         check("bp_extra_result", 32'(out_valid), 32'h0);
                got++;
            end
            tick();
            if (sent == 4 && got == 4) break;
        end
        in_valid = 1'b0;
        check("bp_count", 32'(got), 32'h4);
        #1;
        check("bp_no_dup", 32'(out_valid), 32'h0);
        tick();

        // Reset with both stages full: nothing in flight may ever emerge.
        out_ready = 1'b0;
        a = 16'h1111; b = 16'h0001; bin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h2222; b = 16'h0002;
        tick();
        in_valid = 1'b0;
        check("rm_full_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rm_out_valid", 32'(out_valid), 32'h0);
        check("rm_diff",      32'(diff),      32'h0);
        check("rm_in_ready",  32'(in_ready),  32'h1);
        out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid) stale++;
            tick();
        end
        check("rm_no_stale", 32'(stale), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_lcs_pipe
